// File: rtl/mips_pkg.sv
// Shared constants for the memory arbiter: FSM state encodings and parameter defaults.
// Latency: n/a (compile-time constants only).
// Backpressure: n/a.
package mips_pkg;

    // Arbiter FSM encodings, kept as plain constants for legacy tool flows
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT_I = 2'd1;
    localparam logic [1:0] ST_WAIT_D = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // Consecutive data grants tolerated while a fetch is waiting
    localparam int STARVE_MAX_DEF = 4;

    // Byte address width
    localparam int AW_DEF = 32;

    // A memory response is only expected while a transaction is outstanding
    function automatic logic resp_unexpected(input logic [1:0] st);
        return (st == ST_IDLE) || (st == ST_DONE);
    endfunction

endpackage

// File: rtl/starve_counter.sv
// Saturating starvation counter: counts data grants made while a fetch is pending.
// Latency: count updates on the clock edge after inc/clr; at_max is combinational from count.
// Backpressure: none; inc is ignored once count reaches sat_val, clr has priority over inc.
module starve_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    input  logic [W-1:0] sat_val,
    output logic [W-1:0] count,
    output logic         at_max
);

    assign at_max = (count == sat_val);

    // Clear wins over increment; increment stops at the saturation value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !at_max) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single-port memory, data priority with starvation override.
// Latency: request sampled in IDLE at cycle 0 -> m_req cycle 1 -> earliest m_rvalid cycle 2 -> ready cycle 3.
// Backpressure: requests are held by the requester until its ready pulse; one transaction in flight at a time.
module mem_arbiter
    import mips_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int AW         = AW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [31:0]   i_rdata,
    output logic          i_ready,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    output logic [31:0]   d_rdata,
    output logic          d_ready,
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [31:0]   m_wdata,
    input  logic          m_rvalid,
    input  logic [31:0]   m_rdata,
    output logic          err
);

    localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [1:0]    state;
    logic [CW-1:0] starve_cnt;
    logic          starve_at_max;
    logic          in_idle;
    logic          fetch_win;
    logic          data_win;
    logic          starve_inc;
    logic          starve_clr;

    // Fixed data priority unless the fetch port has been passed over STARVE_MAX times
    always_comb begin
        in_idle    = (state == ST_IDLE);
        fetch_win  = i_req && (!d_req || starve_at_max);
        data_win   = d_req && !fetch_win;
        starve_inc = in_idle && data_win && i_req;
        starve_clr = in_idle && (fetch_win || !i_req);
    end

    starve_counter #(
        .W (CW)
    ) u_starve (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (starve_inc),
        .clr     (starve_clr),
        .sat_val (CW'(STARVE_MAX)),
        .count   (starve_cnt),
        .at_max  (starve_at_max)
    );

    // Transaction FSM: grant in IDLE, issue and wait in WAIT_x, signal completion in DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            m_req   <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            i_rdata <= '0;
            d_rdata <= '0;
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            err     <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below
            m_req   <= 1'b0;
            i_ready <= 1'b0;
            d_ready <= 1'b0;

            // A response with nothing outstanding is flagged and otherwise dropped
            if (m_rvalid && resp_unexpected(state)) begin
                err <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (fetch_win) begin
                        state  <= ST_WAIT_I;
                        m_req  <= 1'b1;
                        m_we   <= 1'b0;
                        m_addr <= i_addr;
                    end else if (data_win) begin
                        state   <= ST_WAIT_D;
                        m_req   <= 1'b1;
                        m_we    <= d_we;
                        m_addr  <= d_addr;
                        m_wdata <= d_wdata;
                    end
                end
                ST_WAIT_I: begin
                    if (m_rvalid) begin
                        i_rdata <= m_rdata;
                        i_ready <= 1'b1;
                        state   <= ST_DONE;
                    end
                end
                ST_WAIT_D: begin
                    if (m_rvalid) begin
                        d_rdata <= m_rdata;
                        d_ready <= 1'b1;
                        state   <= ST_DONE;
                    end
                end
                default: begin
                    // DONE: ready is visible this cycle; no arbitration until IDLE
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, simultaneous, starvation, latency, spurious and reset cases.
// Latency: memory model answers resp_lat cycles after each observed m_req.
// Backpressure: requesters hold req until their ready pulse, then drop it in the following cycle.
module tb_mem_arbiter;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic [31:0]   i_rdata;
    logic          i_ready;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [31:0]   d_wdata = '0;
    logic [31:0]   d_rdata;
    logic          d_ready;
    logic          m_req;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [31:0]   m_wdata;
    logic          m_rvalid;
    logic [31:0]   m_rdata;
    logic          err;

    // Memory model drives resp_*, directed tests drive spur_*
    logic          resp_vld = 1'b0;
    logic [31:0]   resp_rdata = '0;
    logic          spur_vld = 1'b0;
    logic [31:0]   spur_rdata = '0;
    bit            auto_resp = 1'b1;
    int            resp_lat = 1;

    assign m_rvalid = resp_vld | spur_vld;
    assign m_rdata  = spur_vld ? spur_rdata : resp_rdata;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    // Issue and completion logs
    bit          g_we[$];
    logic [31:0] g_addr[$];
    logic [31:0] g_wdata[$];
    int          g_cyc[$];
    int          g_cnt[$];
    int          ir_cyc[$];
    int          dr_cyc[$];

    mem_arbiter #(
        .STARVE_MAX (4),
        .AW         (AW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_rdata  (i_rdata),
        .i_ready  (i_ready),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_rdata  (d_rdata),
        .d_ready  (d_ready),
        .m_req    (m_req),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_rvalid (m_rvalid),
        .m_rdata  (m_rdata),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Cycle index: value seen #1 after a rising edge names that cycle
    always @(posedge clk) cyc <= cyc + 1;

    // Log every issue strobe and ready pulse, sampled mid-cycle
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (m_req === 1'b1) begin
                g_we.push_back(m_we);
                g_addr.push_back(m_addr);
                g_wdata.push_back(m_wdata);
                g_cyc.push_back(cyc);
                g_cnt.push_back(int'(dut.u_starve.count));
            end
            if (i_ready === 1'b1) ir_cyc.push_back(cyc);
            if (d_ready === 1'b1) dr_cyc.push_back(cyc);
        end
    end

    // Memory model: answer resp_lat cycles after the m_req cycle
    always begin
        @(negedge clk);
        if (auto_resp && m_req === 1'b1) begin
            repeat (resp_lat) @(posedge clk);
            #1 resp_vld = 1'b1;
            @(posedge clk);
            #1 resp_vld = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        g_we.delete(); g_addr.delete(); g_wdata.delete();
        g_cyc.delete(); g_cnt.delete(); ir_cyc.delete(); dr_cyc.delete();
    endtask

    task automatic wait_ready(input bit is_d, input int bound, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < bound; c++) begin
            @(negedge clk);
            if ((is_d ? d_ready : i_ready) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if ({m_req, m_we, i_ready, d_ready, err} !== 5'b0) begin n_bad++; $display("FAIL reset_ctl: got %b want 00000", {m_req, m_we, i_ready, d_ready, err}); end
        n_cmp++; if (m_addr !== 32'h0 || m_wdata !== 32'h0) begin n_bad++; $display("FAIL reset_maddr: got %h/%h want 0/0", m_addr, m_wdata); end
        n_cmp++; if (i_rdata !== 32'h0 || d_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h/%h want 0/0", i_rdata, d_rdata); end
        n_cmp++; if (int'(dut.u_starve.count) !== 0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", dut.u_starve.count); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fetch();
        int k0;
        bit ok;
        clear_logs();
        resp_lat = 1;
        resp_rdata = 32'h2002000A;
        i_addr = 32'h40;
        i_req = 1'b1;
        k0 = cyc;
        wait_ready(1'b0, 20, ok);
        tick();
        i_req = 1'b0;
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL fetch_timeout: got no i_ready want i_ready"); end
        n_cmp++; if (g_cyc.size() != 1) begin n_bad++; $display("FAIL fetch_ngrant: got %0d want 1", g_cyc.size()); end
        n_cmp++; if (g_cyc.size() == 0 || g_cyc[0] != k0 + 1 || g_we[0] !== 1'b0 || g_addr[0] !== 32'h40) begin n_bad++; $display("FAIL fetch_issue: got cyc %0d we %b addr %h want cyc %0d we 0 addr 40", (g_cyc.size() > 0) ? g_cyc[0] - k0 : -1, (g_we.size() > 0) ? g_we[0] : 1'bx, (g_addr.size() > 0) ? g_addr[0] : 32'hx, 1); end
        n_cmp++; if (ir_cyc.size() != 1 || ir_cyc[0] != k0 + 3) begin n_bad++; $display("FAIL fetch_ready_cyc: got %0d pulses first at +%0d want 1 at +3", ir_cyc.size(), (ir_cyc.size() > 0) ? ir_cyc[0] - k0 : -1); end
        n_cmp++; if (i_rdata !== 32'h2002000A) begin n_bad++; $display("FAIL fetch_rdata: got %h want 2002000a", i_rdata); end
        n_cmp++; if (dr_cyc.size() != 0) begin n_bad++; $display("FAIL fetch_no_dready: got %0d pulses want 0", dr_cyc.size()); end
    endtask

    task automatic test_simultaneous();
        int k0;
        bit okd, oki;
        logic [31:0] held;
        clear_logs();
        resp_lat = 1;
        resp_rdata = 32'h0BADF00D;
        i_addr = 32'h44;
        d_we = 1'b1;
        d_addr = 32'h100;
        d_wdata = 32'hDEADBEEF;
        i_req = 1'b1;
        d_req = 1'b1;
        k0 = cyc;
        wait_ready(1'b1, 20, okd);
        tick();
        d_req = 1'b0;
        held = i_rdata;
        wait_ready(1'b0, 20, oki);
        tick();
        i_req = 1'b0;
        d_we = 1'b0;
        n_cmp++; if (!okd || !oki) begin n_bad++; $display("FAIL sim_timeout: got d %b i %b want 1 1", okd, oki); end
        n_cmp++; if (held !== 32'h2002000A) begin n_bad++; $display("FAIL sim_irdata_hold: got %h want 2002000a", held); end
        n_cmp++; if (g_cyc.size() != 2) begin n_bad++; $display("FAIL sim_ngrant: got %0d want 2", g_cyc.size()); end
        n_cmp++; if (g_cyc.size() < 1 || g_we[0] !== 1'b1 || g_addr[0] !== 32'h100 || g_wdata[0] !== 32'hDEADBEEF || g_cyc[0] != k0 + 1) begin n_bad++; $display("FAIL sim_first: got we %b addr %h wdata %h want 1 100 deadbeef at +1", (g_we.size() > 0) ? g_we[0] : 1'bx, (g_addr.size() > 0) ? g_addr[0] : 32'hx, (g_wdata.size() > 0) ? g_wdata[0] : 32'hx); end
        n_cmp++; if (g_cyc.size() < 2 || g_we[1] !== 1'b0 || g_addr[1] !== 32'h44 || g_cyc[1] != k0 + 5) begin n_bad++; $display("FAIL sim_second: got %0d grants, second at +%0d want addr 44 we 0 at +5", g_cyc.size(), (g_cyc.size() > 1) ? g_cyc[1] - k0 : -1); end
        n_cmp++; if (dr_cyc.size() != 1 || ir_cyc.size() != 1 || dr_cyc[0] != k0 + 3 || ir_cyc[0] != k0 + 7) begin n_bad++; $display("FAIL sim_ready_order: got d %0d/+%0d i %0d/+%0d want d +3 i +7", dr_cyc.size(), (dr_cyc.size() > 0) ? dr_cyc[0] - k0 : -1, ir_cyc.size(), (ir_cyc.size() > 0) ? ir_cyc[0] - k0 : -1); end
        n_cmp++; if (g_cnt.size() < 2 || g_cnt[0] != 1 || g_cnt[1] != 0) begin n_bad++; $display("FAIL sim_cnt: got %0d/%0d want 1/0", (g_cnt.size() > 0) ? g_cnt[0] : -1, (g_cnt.size() > 1) ? g_cnt[1] : -1); end
        n_cmp++; if (i_rdata !== 32'h0BADF00D) begin n_bad++; $display("FAIL sim_irdata: got %h want 0badf00d", i_rdata); end
    endtask

    task automatic test_starvation();
        bit ok;
        logic [31:0] exp_addr;
        int exp_cnt;
        clear_logs();
        resp_lat = 1;
        resp_rdata = 32'h55AA55AA;
        d_we = 1'b0;
        d_addr = 32'h200;
        i_addr = 32'h80;
        i_req = 1'b1;
        d_req = 1'b1;
        wait_ready(1'b0, 80, ok);
        tick();
        i_req = 1'b0;
        d_req = 1'b0;
        tick();
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL starve_timeout: got no i_ready want i_ready"); end
        n_cmp++; if (g_cyc.size() != 5 || dr_cyc.size() != 4) begin n_bad++; $display("FAIL starve_ngrant: got %0d grants %0d d_ready want 5 and 4", g_cyc.size(), dr_cyc.size()); end
        for (int i = 0; i < 5; i++) begin
            exp_addr = (i < 4) ? 32'h200 : 32'h80;
            exp_cnt  = (i < 4) ? i + 1 : 0;
            n_cmp++;
            if (i >= g_cyc.size() || g_addr[i] !== exp_addr || g_cnt[i] != exp_cnt) begin
                n_bad++;
                $display("FAIL starve_grant%0d: got addr %h cnt %0d want addr %h cnt %0d", i, (i < g_addr.size()) ? g_addr[i] : 32'hx, (i < g_cnt.size()) ? g_cnt[i] : -1, exp_addr, exp_cnt);
            end
        end
        n_cmp++; if (int'(dut.u_starve.count) !== 0) begin n_bad++; $display("FAIL starve_cnt_end: got %0d want 0", dut.u_starve.count); end
    endtask

    task automatic test_var_latency();
        int k0, n_mreq, n_drdy, n_badaddr, rdy_at, grant_at;
        bit seen_grant, seen_rdy;
        clear_logs();
        resp_lat = 7;
        resp_rdata = 32'hCAFE0007;
        d_we = 1'b0;
        d_addr = 32'h300;
        d_req = 1'b1;
        k0 = cyc;
        n_mreq = 0; n_drdy = 0; n_badaddr = 0; rdy_at = -1; grant_at = -1;
        seen_grant = 1'b0; seen_rdy = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (m_req === 1'b1) begin n_mreq++; seen_grant = 1'b1; if (grant_at < 0) grant_at = cyc; end
            if (d_ready === 1'b1) begin n_drdy++; seen_rdy = 1'b1; if (rdy_at < 0) rdy_at = cyc; end
            if (seen_grant && !seen_rdy && m_addr !== 32'h300) n_badaddr++;
            tick();
            if (seen_rdy) d_req = 1'b0;
        end
        resp_lat = 1;
        n_cmp++; if (n_mreq != 1 || grant_at != k0 + 1) begin n_bad++; $display("FAIL lat_mreq: got %0d cycles at +%0d want 1 at +1", n_mreq, grant_at - k0); end
        n_cmp++; if (n_badaddr != 0) begin n_bad++; $display("FAIL lat_addr_stable: got %0d bad cycles want 0", n_badaddr); end
        n_cmp++; if (n_drdy != 1 || rdy_at != k0 + 9) begin n_bad++; $display("FAIL lat_ready: got %0d pulses at +%0d want 1 at +9", n_drdy, rdy_at - k0); end
        n_cmp++; if (d_rdata !== 32'hCAFE0007) begin n_bad++; $display("FAIL lat_rdata: got %h want cafe0007", d_rdata); end
    endtask

    task automatic test_spurious();
        clear_logs();
        spur_rdata = 32'h12345678;
        spur_vld = 1'b1;
        tick();
        spur_vld = 1'b0;
        tick();
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL spur_err: got %b want 1", err); end
        repeat (5) tick();
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL spur_err_sticky: got %b want 1", err); end
        n_cmp++; if (ir_cyc.size() != 0 || dr_cyc.size() != 0 || g_cyc.size() != 0) begin n_bad++; $display("FAIL spur_no_ready: got i %0d d %0d m %0d want 0 0 0", ir_cyc.size(), dr_cyc.size(), g_cyc.size()); end
        n_cmp++; if (d_rdata !== 32'hCAFE0007 || i_rdata !== 32'h55AA55AA) begin n_bad++; $display("FAIL spur_discard: got d %h i %h want cafe0007 55aa55aa", d_rdata, i_rdata); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL spur_err_reset: got %b want 0", err); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid();
        clear_logs();
        auto_resp = 1'b0;
        d_we = 1'b1;
        d_addr = 32'h500;
        d_wdata = 32'hA5A5A5A5;
        d_req = 1'b1;
        tick();
        #2;
        n_cmp++; if (m_req !== 1'b1 || m_we !== 1'b1 || m_addr !== 32'h500) begin n_bad++; $display("FAIL mid_issue: got req %b we %b addr %h want 1 1 500", m_req, m_we, m_addr); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({m_req, m_we, i_ready, d_ready, err} !== 5'b0 || m_addr !== 32'h0 || m_wdata !== 32'h0 || d_rdata !== 32'h0 || i_rdata !== 32'h0) begin n_bad++; $display("FAIL mid_reset_outs: got ctl %b addr %h wdata %h rd %h/%h want all 0", {m_req, m_we, i_ready, d_ready, err}, m_addr, m_wdata, d_rdata, i_rdata); end
        d_req = 1'b0;
        d_we = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        clear_logs();
        spur_rdata = 32'h0000BEEF;
        spur_vld = 1'b1;
        tick();
        spur_vld = 1'b0;
        repeat (4) tick();
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL mid_late_err: got %b want 1", err); end
        n_cmp++; if (dr_cyc.size() != 0 || d_rdata !== 32'h0) begin n_bad++; $display("FAIL mid_no_dready: got %0d pulses rdata %h want 0 0", dr_cyc.size(), d_rdata); end
        auto_resp = 1'b1;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_simultaneous();
        test_starvation();
        test_var_latency();
        test_spurious();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
